// File: rtl/rs_param_station_pkg.sv
// ============================================================================
// Module  : rs_param_station_pkg
// Brief   : Shared defaults, entry layout and tag constants for the station.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rs_param_station_pkg;

    localparam int DEF_DEPTH   = 8;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_OP_W    = 5;
    localparam int DEF_NUM_CDB = 2;

    localparam logic [DEF_TAG_W-1:0] NO_TAG = '0;

    // Reference layout at default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic                 busy;
        logic [DEF_OP_W-1:0]  op;
        logic [DEF_TAG_W-1:0] tag;
        logic                 q1_wait;
        logic [DEF_TAG_W-1:0] q1;
        logic [DEF_XLEN-1:0]  v1;
        logic                 q2_wait;
        logic [DEF_TAG_W-1:0] q2;
        logic [DEF_XLEN-1:0]  v2;
    } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/rs_param_station_if.sv
// ============================================================================
// Module  : rs_param_station_if
// Brief   : Dispatch, result-broadcast and issue bus of the reservation station.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rs_param_station_if
    import rs_param_station_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int NUM_CDB = DEF_NUM_CDB
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [OP_W-1:0]            in_op;
    logic [TAG_W-1:0]           in_tag;
    logic                       in_q1_valid;
    logic [TAG_W-1:0]           in_q1;
    logic [XLEN-1:0]            in_v1;
    logic                       in_q2_valid;
    logic [TAG_W-1:0]           in_q2;
    logic [XLEN-1:0]            in_v2;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*XLEN-1:0]    cdb_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [OP_W-1:0]            out_op;
    logic [TAG_W-1:0]           out_tag;
    logic [XLEN-1:0]            out_v1;
    logic [XLEN-1:0]            out_v2;
    logic [CNT_W-1:0]           free_cnt;

    modport slave (
        input  in_valid, in_op, in_tag, in_q1_valid, in_q1, in_v1,
               in_q2_valid, in_q2, in_v2, cdb_valid, cdb_tag, cdb_data, out_ready,
        output in_ready, out_valid, out_op, out_tag, out_v1, out_v2, free_cnt
    );

    modport master (
        output in_valid, in_op, in_tag, in_q1_valid, in_q1, in_v1,
               in_q2_valid, in_q2, in_v2, cdb_valid, cdb_tag, cdb_data, out_ready,
        input  in_ready, out_valid, out_op, out_tag, out_v1, out_v2, free_cnt
    );

endinterface

`default_nettype wire

// File: rtl/rs_age_matrix.sv
// ============================================================================
// Module  : rs_age_matrix
// Brief   : Relative-age tracker selecting the oldest ready entry (one-hot).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ins_en,
    input  logic [$clog2(DEPTH)-1:0]   ins_idx,
    input  logic [DEPTH-1:0]           free_mask,
    input  logic [DEPTH-1:0]           ready_mask,
    output logic [DEPTH-1:0]           oldest,
    output logic                       any_ready
);

    // r_age[i][j] = 1 : entry i entered before entry j
    logic [DEPTH-1:0][DEPTH-1:0] r_age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age <= '0;
        end else if (ins_en) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_age[ins_idx][j] <= 1'b0;
                r_age[j][ins_idx] <= ~free_mask[j];
            end
        end
    end

    always_comb begin
        oldest = ready_mask;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_mask[j] && r_age[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    assign any_ready = |ready_mask;

endmodule

`default_nettype wire

// File: rtl/rs_param_station.sv
// ============================================================================
// Module  : rs_param_station
// Brief   : Parametrised reservation station with CDB wakeup and oldest-first issue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_param_station
    import rs_param_station_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int NUM_CDB = DEF_NUM_CDB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    rs_param_station_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic             q1_wait;
        logic [TAG_W-1:0] q1;
        logic [XLEN-1:0]  v1;
        logic             q2_wait;
        logic [TAG_W-1:0] q2;
        logic [XLEN-1:0]  v2;
    } entry_t;

    logic [DEPTH-1:0]              r_busy;
    entry_t [DEPTH-1:0]            r_ent;
    logic [CNT_W-1:0]              r_free_cnt;
    logic                          r_out_valid;
    logic [OP_W-1:0]               r_out_op;
    logic [TAG_W-1:0]              r_out_tag;
    logic [XLEN-1:0]               r_out_v1;
    logic [XLEN-1:0]               r_out_v2;

    logic [NUM_CDB-1:0]            w_cvalid;
    logic [NUM_CDB-1:0][TAG_W-1:0] w_ctag;
    logic [NUM_CDB-1:0][XLEN-1:0]  w_cdata;
    logic [DEPTH-1:0][XLEN:0]      w_wk1;
    logic [DEPTH-1:0][XLEN:0]      w_wk2;
    logic [XLEN:0]                 w_in1_res;
    logic [XLEN:0]                 w_in2_res;
    entry_t                        w_new_ent;
    logic [DEPTH-1:0]              w_ready;
    logic [DEPTH-1:0]              w_free_mask;
    logic [DEPTH-1:0]              w_oldest;
    logic                          w_any_ready;
    logic [IDX_W-1:0]              w_ins_idx;
    logic [IDX_W-1:0]              w_sel_idx;
    logic                          w_in_ready;
    logic                          w_ins_fire;
    logic                          w_issue_fire;

    assign w_cvalid = bus.cdb_valid;

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
        assign w_ctag[k]  = bus.cdb_tag[k*TAG_W +: TAG_W];
        assign w_cdata[k] = bus.cdb_data[k*XLEN +: XLEN];
    end

    // Returns {hit, data}; scanning downwards lets the lowest matching port win.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (w_cvalid[k] && (w_ctag[k] == tag)) begin
                res = {1'b1, w_cdata[k]};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_in1_res = cdb_lookup(bus.in_q1);
        w_in2_res = cdb_lookup(bus.in_q2);
        w_new_ent         = '0;
        w_new_ent.op      = bus.in_op;
        w_new_ent.tag     = bus.in_tag;
        w_new_ent.q1      = TAG_W'(NO_TAG);
        w_new_ent.q2      = TAG_W'(NO_TAG);
        w_new_ent.v1      = bus.in_v1;
        w_new_ent.v2      = bus.in_v2;
        if (bus.in_q1_valid) begin
            if (w_in1_res[XLEN]) begin
                w_new_ent.v1 = w_in1_res[XLEN-1:0];
            end else begin
                w_new_ent.q1_wait = 1'b1;
                w_new_ent.q1      = bus.in_q1;
            end
        end
        if (bus.in_q2_valid) begin
            if (w_in2_res[XLEN]) begin
                w_new_ent.v2 = w_in2_res[XLEN-1:0];
            end else begin
                w_new_ent.q2_wait = 1'b1;
                w_new_ent.q2      = bus.in_q2;
            end
        end
    end

    always_comb begin
        w_wk1     = '0;
        w_wk2     = '0;
        w_ready   = '0;
        w_ins_idx = '0;
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i]   = cdb_lookup(r_ent[i].q1);
            w_wk2[i]   = cdb_lookup(r_ent[i].q2);
            w_ready[i] = r_busy[i] && !r_ent[i].q1_wait && !r_ent[i].q2_wait;
            if (w_oldest[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_ins_idx = IDX_W'(i);
            end
        end
    end

    assign w_free_mask  = ~r_busy;
    assign w_in_ready   = (r_free_cnt != '0);
    assign w_ins_fire   = rdy && !flush && bus.in_valid && w_in_ready;
    assign w_issue_fire = rdy && !flush && w_any_ready && (!r_out_valid || bus.out_ready);

    rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk        (clk),
        .rst        (rst),
        .ins_en     (w_ins_fire),
        .ins_idx    (w_ins_idx),
        .free_mask  (w_free_mask),
        .ready_mask (w_ready),
        .oldest     (w_oldest),
        .any_ready  (w_any_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_ent  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_busy[i] && r_ent[i].q1_wait && w_wk1[i][XLEN]) begin
                        r_ent[i].q1_wait <= 1'b0;
                        r_ent[i].v1      <= w_wk1[i][XLEN-1:0];
                    end
                    if (r_busy[i] && r_ent[i].q2_wait && w_wk2[i][XLEN]) begin
                        r_ent[i].q2_wait <= 1'b0;
                        r_ent[i].v2      <= w_wk2[i][XLEN-1:0];
                    end
                end
                if (w_issue_fire) begin
                    r_busy[w_sel_idx] <= 1'b0;
                end
                // Insert slot comes from the pre-edge free mask, so it never collides with the issued one.
                if (w_ins_fire) begin
                    r_busy[w_ins_idx] <= 1'b1;
                    r_ent[w_ins_idx]  <= w_new_ent;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_free_cnt  <= CNT_W'(DEPTH);
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_tag   <= '0;
            r_out_v1    <= '0;
            r_out_v2    <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_free_cnt  <= CNT_W'(DEPTH);
                r_out_valid <= 1'b0;
            end else begin
                r_free_cnt <= r_free_cnt + CNT_W'(w_issue_fire) - CNT_W'(w_ins_fire);
                if (w_issue_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_op    <= r_ent[w_sel_idx].op;
                    r_out_tag   <= r_ent[w_sel_idx].tag;
                    r_out_v1    <= r_ent[w_sel_idx].v1;
                    r_out_v2    <= r_ent[w_sel_idx].v2;
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.free_cnt  = r_free_cnt;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_out_op;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_v1    = r_out_v1;
    assign bus.out_v2    = r_out_v2;

endmodule

`default_nettype wire

// File: tb/tb_rs_param_station.sv
// ============================================================================
// Module  : tb_rs_param_station
// Brief   : Self-checking bench for rs_param_station against an in-order queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rs_param_station;

    localparam int DEPTH   = 8;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 5;
    localparam int NUM_CDB = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    rs_param_station_if #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
    ) bus ();

    rs_param_station #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: entries kept in arrival order, so the oldest ready one is simply the first ready one.
    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        bit               w1;
        logic [TAG_W-1:0] q1;
        logic [XLEN-1:0]  v1;
        bit               w2;
        logic [TAG_W-1:0] q2;
        logic [XLEN-1:0]  v2;
    } ment_t;

    ment_t            mq[$];
    bit               m_ov;
    logic [OP_W-1:0]  m_op;
    logic [TAG_W-1:0] m_tag;
    logic [XLEN-1:0]  m_v1;
    logic [XLEN-1:0]  m_v2;

    function automatic void lookup(input logic [TAG_W-1:0] t, output bit hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!hit && bus.cdb_valid[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == t) begin
                hit = 1'b1;
                d   = bus.cdb_data[k*XLEN +: XLEN];
            end
        end
    endfunction

    task automatic model_edge();
        int               sel;
        bit               acc;
        bit               h;
        logic [XLEN-1:0]  d;
        ment_t            e;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            m_ov = 1'b0;
            return;
        end
        acc = bus.in_valid && (mq.size() < DEPTH);
        sel = -1;
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && !mq[i].w1 && !mq[i].w2) sel = i;
        if (sel >= 0 && (!m_ov || bus.out_ready)) begin
            m_ov = 1'b1;
            m_op = mq[sel].op; m_tag = mq[sel].tag; m_v1 = mq[sel].v1; m_v2 = mq[sel].v2;
            mq.delete(sel);
        end else if (m_ov && bus.out_ready) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].w1) begin lookup(mq[i].q1, h, d); if (h) begin mq[i].w1 = 1'b0; mq[i].v1 = d; end end
            if (mq[i].w2) begin lookup(mq[i].q2, h, d); if (h) begin mq[i].w2 = 1'b0; mq[i].v2 = d; end end
        end
        if (acc) begin
            e.op = bus.in_op; e.tag = bus.in_tag;
            e.w1 = bus.in_q1_valid; e.q1 = bus.in_q1; e.v1 = bus.in_v1;
            e.w2 = bus.in_q2_valid; e.q2 = bus.in_q2; e.v2 = bus.in_v2;
            if (e.w1) begin lookup(e.q1, h, d); if (h) begin e.w1 = 1'b0; e.v1 = d; end end
            if (e.w2) begin lookup(e.q2, h, d); if (h) begin e.w2 = 1'b0; e.v2 = d; end end
            mq.push_back(e);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.cdb_valid = '0;
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                            input bit q1v, input logic [TAG_W-1:0] q1, input logic [XLEN-1:0] v1,
                            input bit q2v, input logic [TAG_W-1:0] q2, input logic [XLEN-1:0] v2);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_tag = tag;
        bus.in_q1_valid = q1v; bus.in_q1 = q1; bus.in_v1 = v1;
        bus.in_q2_valid = q2v; bus.in_q2 = q2; bus.in_v2 = v2;
    endtask

    task automatic cdb(input int k, input bit v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
        bus.cdb_valid[k] = v;
        bus.cdb_tag[k*TAG_W +: TAG_W] = t;
        bus.cdb_data[k*XLEN +: XLEN]  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        bus.in_op = '0; bus.in_tag = '0; bus.in_q1_valid = 1'b0; bus.in_q1 = '0; bus.in_v1 = '0;
        bus.in_q2_valid = 1'b0; bus.in_q2 = '0; bus.in_v2 = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.free_cnt !== 4'd8) begin miscompares++; $display("FAIL reset_free_cnt: got %0d want 8", bus.free_cnt); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); rst = 1'b1;
        mq.delete(); m_ov = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_age_order();
        logic [TAG_W-1:0] exp_tag[3] = '{4'd1, 4'd2, 4'd3};
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) dispatch(5'(c + 1), exp_tag[c], 1'b0, '0, 32'hA0 + c, 1'b0, '0, 32'hB0 + c);
            else bus.in_valid = 1'b0;
            step();
            if (c >= 1) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 || bus.out_v1 !== 32'hA0 || bus.out_v2 !== 32'hB0) begin
                    miscompares++;
                    $display("FAIL age_stall c=%0d: valid=%b tag=%0d v1=%h v2=%h want 1/1/a0/b0", c, bus.out_valid, bus.out_tag, bus.out_v1, bus.out_v2);
                end
            end
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (c < 2) begin
                if (bus.out_valid !== 1'b1 || bus.out_tag !== exp_tag[c + 1] || bus.out_op !== 5'(c + 2)) begin
                    miscompares++;
                    $display("FAIL age_order c=%0d: valid=%b tag=%0d op=%0d want 1/%0d/%0d", c, bus.out_valid, bus.out_tag, bus.out_op, exp_tag[c + 1], c + 2);
                end
            end else if (bus.out_valid !== 1'b0 || bus.free_cnt !== 4'd8) begin
                miscompares++;
                $display("FAIL age_drain: valid=%b free=%0d want 0/8", bus.out_valid, bus.free_cnt);
            end
        end
    endtask

    task automatic test_wakeup();
        bus.out_ready = 1'b1;
        dispatch(5'd2, 4'd5, 1'b1, 4'd9, 32'h0, 1'b0, '0, 32'h1234);
        step();
        idle();
        cdb(1, 1'b1, 4'd9, 32'hDEAD);
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL wakeup_early: got valid=%b want 0", bus.out_valid); end
        idle();
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd5 || bus.out_v1 !== 32'hDEAD || bus.out_v2 !== 32'h1234) begin
            miscompares++;
            $display("FAIL wakeup_issue: valid=%b tag=%0d v1=%h v2=%h want 1/5/dead/1234", bus.out_valid, bus.out_tag, bus.out_v1, bus.out_v2);
        end
        step();
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b1;
        dispatch(5'd3, 4'd6, 1'b0, '0, 32'h7, 1'b1, 4'd4, 32'h0);
        cdb(0, 1'b1, 4'd4, 32'h55);
        cdb(1, 1'b1, 4'd4, 32'h66);
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bypass_early: got valid=%b want 0", bus.out_valid); end
        idle();
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd6 || bus.out_v2 !== 32'h55 || bus.out_v1 !== 32'h7) begin
            miscompares++;
            $display("FAIL bypass_issue: valid=%b tag=%0d v1=%h v2=%h want 1/6/7/55", bus.out_valid, bus.out_tag, bus.out_v1, bus.out_v2);
        end
        step();
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            dispatch(5'(c), 4'(c), 1'b0, '0, 32'(c), 1'b0, '0, 32'(c * 3));
            step();
        end
        idle();
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.free_cnt !== 4'd0) begin
            miscompares++; $display("FAIL full_state: in_ready=%b free=%0d want 0/0", bus.in_ready, bus.free_cnt);
        end
        dispatch(5'd12, 4'd12, 1'b0, '0, 32'hC, 1'b0, '0, 32'hC);
        bus.out_ready = 1'b1;
        step();
        vectors++;
        if (bus.free_cnt !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1) begin
            miscompares++; $display("FAIL full_concurrent: free=%0d valid=%b tag=%0d want 1/1/1", bus.free_cnt, bus.out_valid, bus.out_tag);
        end
        bus.out_ready = 1'b0;
        step();
        vectors++; if (bus.free_cnt !== 4'd0) begin miscompares++; $display("FAIL full_accept: free=%0d want 0", bus.free_cnt); end
        idle();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            step();
            vectors++;
            if (bus.out_valid !== m_ov || (m_ov && bus.out_tag !== m_tag) || bus.free_cnt !== 4'(DEPTH - mq.size())) begin
                miscompares++;
                $display("FAIL full_drain c=%0d: valid=%b tag=%0d free=%0d want %b/%0d/%0d", c, bus.out_valid, bus.out_tag, bus.free_cnt, m_ov, m_tag, DEPTH - mq.size());
            end
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            dispatch(5'(c), 4'(c + 8), 1'b0, '0, 32'(c), 1'b0, '0, 32'(c));
            step();
        end
        idle();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.free_cnt !== 4'd3) begin
            miscompares++; $display("FAIL flush_setup: valid=%b free=%0d want 1/3", bus.out_valid, bus.free_cnt);
        end
        flush = 1'b1;
        dispatch(5'd1, 4'd14, 1'b0, '0, 32'h1, 1'b0, '0, 32'h1);
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.free_cnt !== 4'd8 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush: valid=%b free=%0d in_ready=%b want 0/8/1", bus.out_valid, bus.free_cnt, bus.in_ready);
        end
        idle();
        bus.out_ready = 1'b1;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.free_cnt !== 4'd8) begin
            miscompares++; $display("FAIL flush_dropped: valid=%b free=%0d want 0/8", bus.out_valid, bus.free_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6)
                dispatch(5'($urandom), 4'($urandom), ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)), $urandom,
                         ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)), $urandom);
            else
                bus.in_valid = 1'b0;
            for (int k = 0; k < NUM_CDB; k++)
                cdb(k, ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)), $urandom);
            step();
            vectors++;
            if (bus.out_valid !== m_ov || bus.in_ready !== (mq.size() < DEPTH) || bus.free_cnt !== 4'(DEPTH - mq.size())) begin
                miscompares++;
                $display("FAIL rand_status c=%0d: valid=%b in_ready=%b free=%0d want %b/%b/%0d", c, bus.out_valid, bus.in_ready, bus.free_cnt, m_ov, mq.size() < DEPTH, DEPTH - mq.size());
            end
            if (m_ov) begin
                vectors++;
                if (bus.out_op !== m_op || bus.out_tag !== m_tag || bus.out_v1 !== m_v1 || bus.out_v2 !== m_v2) begin
                    miscompares++;
                    $display("FAIL rand_payload c=%0d: op=%0d tag=%0d v1=%h v2=%h want %0d/%0d/%h/%h", c, bus.out_op, bus.out_tag, bus.out_v1, bus.out_v2, m_op, m_tag, m_v1, m_v2);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        idle();
        flush = 1'b1;
        step();
        idle();
        bus.out_ready = 1'b0;
        dispatch(5'd1, 4'd1, 1'b0, '0, 32'h1, 1'b0, '0, 32'h1);
        step();
        for (int c = 0; c < 3; c++) begin
            dispatch(5'd2, 4'(c + 2), 1'b1, 4'd15, 32'h0, 1'b0, '0, 32'h2);
            step();
        end
        idle();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.free_cnt !== 4'd5) begin
            miscompares++; $display("FAIL midreset_setup: valid=%b free=%0d want 1/5", bus.out_valid, bus.free_cnt);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.free_cnt !== 4'd8 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL midreset_async: valid=%b free=%0d in_ready=%b want 0/8/1", bus.out_valid, bus.free_cnt, bus.in_ready);
        end
        mq.delete(); m_ov = 1'b0;
        @(negedge clk); rst = 1'b1;
        bus.out_ready = 1'b1;
        dispatch(5'd9, 4'd9, 1'b0, '0, 32'h99, 1'b0, '0, 32'h98);
        #1;
        step();
        idle();
        step();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd9 || bus.free_cnt !== 4'd8) begin
            miscompares++; $display("FAIL midreset_resume: valid=%b tag=%0d free=%0d want 1/9/8", bus.out_valid, bus.out_tag, bus.free_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_age_order();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
